// File: rtl/ro_meter_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter.
// Latency: none (package only).
// Backpressure: none (package only).
package ro_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Two flops is the minimum that gives a usable MTBF on the oscillator input.
    localparam int SYNC_STAGES_DEF = 2;

    // Width of the shared warm-up/gate timer: must hold the larger of the two lengths.
    function automatic int timer_width(input int gate_cycles, input int warmup_cycles);
        int m;
        m = (gate_cycles > warmup_cycles) ? gate_cycles : warmup_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ro_freq_meter_sync_edge.sv
// Synchronizes the asynchronous oscillator output and flags its rising edges.
// Latency: SYNC_STAGES clk cycles from ro_data to the edge pulse.
// Backpressure: none; free-running, one edge pulse per detected rising edge.
module ro_sync_edge
    import ro_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ro_freq_meter.sv
// Enables the ring oscillator, warms it up, then counts its rising edges over a fixed clk window.
// Latency: result_valid 1+WARMUP_CYCLES+GATE_CYCLES cycles after start; GATE_CYCLES+1 apart when continuous.
// Backpressure: none; start is ignored while busy. Optional RO_METER_MINMAX_EN adds cnt_min/cnt_max.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int GATE_CYCLES   = 1024,
    parameter int WARMUP_CYCLES = 16,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             ro_data,
    output logic             ro_enable,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
`ifdef RO_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] cnt_min,
    output logic [CNT_W-1:0] cnt_max
`endif
);

    localparam int TMR_W = timer_width(GATE_CYCLES, WARMUP_CYCLES);
    localparam logic [TMR_W-1:0] WARM_LAST = TMR_W'(WARMUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_win_ovf;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_win_ovf_nxt;
    logic               w_win_end;
    logic               w_rise;
    logic               w_ro_level_unused;
    logic               r_ro_enable;
    logic [CNT_W-1:0]   r_result;
    logic               r_result_valid;
    logic               r_overflow;

    // The synced level is exported by the sub-module for debug; only the edge pulse matters here.
    ro_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .i_rst_n (rst),
        .i_async (ro_data),
        .o_level (w_ro_level_unused),
        .o_rise  (w_rise)
    );

    assign w_win_end = (r_state == MEASURE) && (r_timer == GATE_LAST);

    // Next-state logic: warm-up and window lengths come from the shared timer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = WARMUP;
            WARMUP:  if (r_timer == WARM_LAST) w_state_nxt = MEASURE;
            MEASURE: if (r_timer == GATE_LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = continuous ? MEASURE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Saturating edge count; the window flag records any increment lost at saturation.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_win_ovf_nxt = r_win_ovf;
        if ((r_state == MEASURE) && w_rise) begin
            if (r_cnt == '1) begin
                w_win_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // State register plus registered enable/valid derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_ro_enable    <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ro_enable    <= (w_state_nxt != IDLE);
            r_result_valid <= (w_state_nxt == DONE);
        end
    end

    // Phase timer restarts on every state change so each phase counts from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Edge counter only accumulates in MEASURE; every other state leaves it cleared for the next window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_win_ovf <= 1'b0;
        end else if (r_state == MEASURE) begin
            r_cnt     <= w_cnt_nxt;
            r_win_ovf <= w_win_ovf_nxt;
        end else begin
            r_cnt     <= '0;
            r_win_ovf <= 1'b0;
        end
    end

    // Capture the final count (including an edge in the last window cycle) as DONE is entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_win_end) begin
            r_result   <= w_cnt_nxt;
            r_overflow <= w_win_ovf_nxt;
        end
    end

`ifdef RO_METER_MINMAX_EN
    logic [CNT_W-1:0] r_cnt_min;
    logic [CNT_W-1:0] r_cnt_max;

    // Track extremes across windows; a fresh start from IDLE reopens the tracking range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt_min <= '1;
            r_cnt_max <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_cnt_min <= '1;
            r_cnt_max <= '0;
        end else if (w_win_end) begin
            if (w_cnt_nxt < r_cnt_min) r_cnt_min <= w_cnt_nxt;
            if (w_cnt_nxt > r_cnt_max) r_cnt_max <= w_cnt_nxt;
        end
    end

    assign cnt_min = r_cnt_min;
    assign cnt_max = r_cnt_max;
`endif

    assign ro_enable    = r_ro_enable;
    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;

endmodule
